// File: rtl/viterbi_pkg.sv
// Shared constants, types and trellis helpers for the K=3, rate-1/2 hard-decision Viterbi decoder.
package viterbi_pkg;

    localparam int K          = 3;
    localparam int NUM_STATES = 1 << (K - 1);

    // Generator taps, applied to the register {u, s1, s0}
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    typedef logic [1:0]   bm_t;
    typedef logic [K-2:0] state_t;

    function automatic logic [1:0] exp_sym(input state_t s, input logic u);
        logic [K-1:0] reg_v;
        reg_v = {u, s};
        return {^(reg_v & G0), ^(reg_v & G1)};
    endfunction

    function automatic bm_t hamming(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// One add-compare-select cell: saturating metric sums, ties resolved toward predecessor a (s0 = 0).
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm_a,
    input  bm_t             bm_a,
    input  logic [PM_W-1:0] pm_b,
    input  bm_t             bm_b,
    output logic [PM_W-1:0] pm_out,
    output logic            sel_b
);

    logic [PM_W:0]   sum_a;
    logic [PM_W:0]   sum_b;
    logic [PM_W-1:0] sat_a;
    logic [PM_W-1:0] sat_b;

    always_comb begin
        sum_a  = {1'b0, pm_a} + {{(PM_W - 1){1'b0}}, bm_a};
        sum_b  = {1'b0, pm_b} + {{(PM_W - 1){1'b0}}, bm_b};
        sat_a  = sum_a[PM_W] ? '1 : sum_a[PM_W-1:0];
        sat_b  = sum_b[PM_W] ? '1 : sum_b[PM_W-1:0];
        sel_b  = (sat_b < sat_a);
        pm_out = sel_b ? sat_b : sat_a;
    end

endmodule

// File: rtl/viterbi_decoder.sv
// Register-exchange Viterbi decoder for the (7,5) K=3 code with fixed decision depth TB_DEPTH.
// Define VITERBI_ERR_CNT_EN to add the err_cnt output (accumulated normalisation amount).
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  d_in,
`ifdef VITERBI_ERR_CNT_EN
    output logic [15:0] err_cnt,
`endif
    output logic        d_out
);

    typedef logic [PM_W-1:0]     pm_t;
    typedef logic [TB_DEPTH-1:0] surv_t;

    localparam pm_t RST_PM = pm_t'(1 << (PM_W - 2));

    pm_t    pm_q   [NUM_STATES];
    pm_t    pm_d   [NUM_STATES];
    surv_t  surv_q [NUM_STATES];
    surv_t  surv_d [NUM_STATES];
    logic   d_out_q, d_out_d;

    pm_t    acs_pm  [NUM_STATES];
    logic   acs_sel [NUM_STATES];
    pm_t    pm_min;
    state_t best;

    // Next state {u, s1} is reached from {s1, 0} (port a) or {s1, 1} (port b)
    for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
        localparam int U  = ns / 2;
        localparam int PA = (ns % 2) * 2;
        bm_t bm_a;
        bm_t bm_b;

        assign bm_a = hamming(d_in, exp_sym(state_t'(PA), U[0]));
        assign bm_b = hamming(d_in, exp_sym(state_t'(PA + 1), U[0]));

        viterbi_acs #(.PM_W(PM_W)) u_acs (
            .pm_a  (pm_q[PA]),
            .bm_a  (bm_a),
            .pm_b  (pm_q[PA + 1]),
            .bm_b  (bm_b),
            .pm_out(acs_pm[ns]),
            .sel_b (acs_sel[ns])
        );
    end

    always_comb begin
        pm_min = acs_pm[0];
        best   = '0;
        for (int s = 1; s < NUM_STATES; s++) begin
            if (acs_pm[s] < pm_min) begin
                pm_min = acs_pm[s];
                best   = state_t'(s);
            end
        end

        for (int s = 0; s < NUM_STATES; s++) begin
            pm_d[s]   = pm_q[s];
            surv_d[s] = surv_q[s];
        end
        d_out_d = d_out_q;

        if (enable) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                pm_d[s]   = acs_pm[s] - pm_min;
                surv_d[s] = {surv_q[(s % 2) * 2 + int'(acs_sel[s])][TB_DEPTH-2:0],
                             (s >= NUM_STATES / 2)};
            end
            d_out_d = surv_d[best][TB_DEPTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                pm_q[s]   <= (s == 0) ? '0 : RST_PM;
                surv_q[s] <= '0;
            end
            d_out_q <= 1'b0;
        end else begin
            for (int s = 0; s < NUM_STATES; s++) begin
                pm_q[s]   <= pm_d[s];
                surv_q[s] <= surv_d[s];
            end
            d_out_q <= d_out_d;
        end
    end

    assign d_out = d_out_q;

`ifdef VITERBI_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;

    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + 17'(pm_min);
        err_cnt_d = err_cnt_q;
        if (enable) begin
            err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed self-checking bench for viterbi_decoder: reference encoder, error injection, enable gaps, resets.
module tb_viterbi_decoder;

    localparam int TB_DEPTH = 16;
    localparam int PM_W     = 6;
    localparam int NBITS    = 256;
    localparam int NOUT     = NBITS + TB_DEPTH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] d_in = 2'b00;
    logic       d_out;
`ifdef VITERBI_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic src     [NBITS];
    logic dec_out [NOUT];
    logic dec_ref [NOUT];
    int   mism, zero_bad, unstable, ref_bad, flips, total_run;

    always #5 clk = ~clk;

    viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .d_in   (d_in),
`ifdef VITERBI_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .d_out  (d_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_src(input logic [15:0] seed);
        logic [15:0] lfsr;
        lfsr = seed;
        for (int i = 0; i < NBITS; i++) begin
            lfsr   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            src[i] = lfsr[0];
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        d_in   = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // mode 0: clean, 1: one flipped bit every 20 symbols, 2: both bits flipped every 24 symbols
    task automatic run_stream(input int nbits, input int mode, input bit gaps, input bit flush);
        logic [1:0] st;
        logic [1:0] sym;
        logic       u;
        logic       prev;
        st = 2'b00;
        mism = 0; zero_bad = 0; unstable = 0; flips = 0;
        total_run = flush ? nbits + TB_DEPTH - 1 : nbits;
        for (int j = 0; j < total_run; j++) begin
            if (gaps) begin
                for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) begin
                    enable = 1'b0;
                    d_in   = 2'($urandom_range(0, 3));
                    prev   = d_out;
                    @(posedge clk);
                    #1;
                    if (d_out !== prev) unstable++;
                end
            end
            u   = (j < nbits) ? src[j] : 1'b0;
            sym = {u ^ st[1] ^ st[0], u ^ st[0]};
            st  = {u, st[1]};
            if (j < nbits && mode == 1 && j % 20 == 10) begin
                sym ^= ((j / 20) % 2 == 1) ? 2'b01 : 2'b10;
                flips++;
            end
            if (j < nbits && mode == 2 && j % 24 == 12) begin
                sym ^= 2'b11;
                flips += 2;
            end
            enable = 1'b1;
            d_in   = sym;
            @(posedge clk);
            #1;
            dec_out[j] = d_out;
            if (j >= TB_DEPTH - 1) begin
                if (d_out !== src[j - TB_DEPTH + 1]) mism++;
            end else if (d_out !== 1'b0) begin
                zero_bad++;
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with enable toggling must keep the initial metrics
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            enable = i[0];
            d_in   = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        check_eq("rst_d_out", 32'(d_out), 32'd0);
        check_eq("rst_pm0", 32'(dut.pm_q[0]), 32'd0);
        check_eq("rst_pm1", 32'(dut.pm_q[1]), 32'd16);
        check_eq("rst_pm2", 32'(dut.pm_q[2]), 32'd16);
        check_eq("rst_pm3", 32'(dut.pm_q[3]), 32'd16);
        check_eq("rst_surv2", 32'(dut.surv_q[2]), 32'd0);
`ifdef VITERBI_ERR_CNT_EN
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif

        fill_src(16'hACE1);
        do_reset();
        run_stream(NBITS, 0, 1'b0, 1'b1);
        check_eq("clean_mism", mism, 0);
        check_eq("clean_first_zero", zero_bad, 0);
`ifdef VITERBI_ERR_CNT_EN
        check_eq("clean_err_cnt", 32'(err_cnt), 32'd0);
`endif
        for (int j = 0; j < total_run; j++) dec_ref[j] = dec_out[j];

        do_reset();
        run_stream(NBITS, 1, 1'b0, 1'b1);
        check_eq("single_err_mism", mism, 0);
        check_eq("single_err_flips", flips, 13);
`ifdef VITERBI_ERR_CNT_EN
        check_eq("single_err_cnt", 32'(err_cnt), 32'd13);
`endif

        do_reset();
        run_stream(NBITS, 2, 1'b0, 1'b1);
        check_eq("burst_err_mism", mism, 0);

        do_reset();
        run_stream(NBITS, 0, 1'b1, 1'b1);
        check_eq("gap_mism", mism, 0);
        check_eq("gap_stable", unstable, 0);
        ref_bad = 0;
        for (int j = 0; j < total_run; j++) begin
            if (dec_out[j] !== dec_ref[j]) ref_bad++;
        end
        check_eq("gap_vs_cont", ref_bad, 0);

        // Asynchronous reset in the middle of a stream
        fill_src(16'h5A3C);
        do_reset();
        run_stream(100, 0, 1'b0, 1'b0);
        check_eq("pre_rst_mism", mism, 0);
        enable = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_d_out", 32'(d_out), 32'd0);
        check_eq("mid_rst_pm0", 32'(dut.pm_q[0]), 32'd0);
        check_eq("mid_rst_pm3", 32'(dut.pm_q[3]), 32'd16);
        @(posedge clk);
        #1 rst = 1'b0;
        enable = 1'b0;
        fill_src(16'h1F2E);
        run_stream(120, 0, 1'b0, 1'b1);
        check_eq("post_rst_mism", mism, 0);
        check_eq("post_rst_first_zero", zero_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
